// File: rtl/encoded_monitor.sv
// Downstream checker for the 2-bit encoded sequence FSM: counts transitions,
// measures dwell time, and flags illegal transitions and data/state mismatches.
module encoded_monitor #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [1:0]       estados,
    input  logic [1:0]       data_in,
    output logic [CNT_W-1:0] trans_count,
    output logic [CNT_W-1:0] dwell_count,
    output logic             dwell_timeout,
    output logic             illegal_flag,
    output logic [1:0]       illegal_from,
    output logic [1:0]       illegal_to,
    output logic             mismatch_flag
);

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        TRACK = 2'b01,
        ERROR = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t     state;
    logic [1:0] prev;
    logic       changed;
    logic       legal;
    logic       data_ok;

    always_comb begin
        changed = (estados != prev);
        case ({prev, estados})
            4'b00_01, 4'b01_01, 4'b01_10, 4'b10_11,
            4'b10_01, 4'b11_10, 4'b11_11: legal = 1'b1;
            default:                      legal = 1'b0;
        endcase
        // Each state drives the code one step ahead of itself (mod 4).
        data_ok       = (data_in == estados + 2'd1);
        dwell_timeout = (dwell_count >= TIMEOUT_C);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= INIT;
            prev          <= '0;
            trans_count   <= '0;
            dwell_count   <= '0;
            illegal_flag  <= 1'b0;
            illegal_from  <= '0;
            illegal_to    <= '0;
            mismatch_flag <= 1'b0;
        end else if (clear) begin
            state         <= INIT;
            prev          <= '0;
            trans_count   <= '0;
            dwell_count   <= '0;
            illegal_flag  <= 1'b0;
            illegal_from  <= '0;
            illegal_to    <= '0;
            mismatch_flag <= 1'b0;
        end else begin
            case (state)
                TRACK, ERROR: begin
                    if (changed) begin
                        if (trans_count != CNT_MAX)
                            trans_count <= trans_count + 1'b1;
                        dwell_count <= '0;
                        prev        <= estados;
                    end else if (dwell_count != CNT_MAX) begin
                        dwell_count <= dwell_count + 1'b1;
                    end
                    // Only the first illegal pair is captured; ERROR is absorbing.
                    if (state == TRACK && !legal) begin
                        illegal_flag <= 1'b1;
                        illegal_from <= prev;
                        illegal_to   <= estados;
                        state        <= ERROR;
                    end
                    if (!data_ok)
                        mismatch_flag <= 1'b1;
                end
                default: begin
                    prev        <= estados;
                    dwell_count <= '0;
                    state       <= TRACK;
                end
            endcase
        end
    end

endmodule
